// File: rtl/arm_sequencer.sv
// Pick-and-place sequencer: latches pick/place targets and ramps x/y towards them
// in fixed Q16.16 steps on a motion tick, sequencing gripper close/open along the way.
module arm_sequencer #(
    parameter logic [31:0] TICK_DIV = 32'd50_000,
    parameter logic [31:0] STEP     = 32'h0000_1000,
    parameter logic [31:0] DWELL    = 32'd25_000_000,
    parameter logic [31:0] HOME_X   = 32'h0000_0000,
    parameter logic [31:0] HOME_Y   = 32'h001E_9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] pick_x,
    input  logic [31:0] pick_y,
    input  logic [31:0] place_x,
    input  logic [31:0] place_y,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic        en,
    output logic        catch,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TO_PICK  = 3'd1,
        ST_GRIP     = 3'd2,
        ST_TO_PLACE = 3'd3,
        ST_RELEASE  = 3'd4,
        ST_TO_HOME  = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] x_r, x_s, y_r, y_s;
    logic [31:0] tick_r, tick_s, dwell_r, dwell_s;
    logic [31:0] pick_x_r, pick_x_s, pick_y_r, pick_y_s;
    logic [31:0] place_x_r, place_x_s, place_y_r, place_y_s;
    logic        en_r, en_s, catch_r, catch_s, busy_r, busy_s, done_r, done_s;
    logic        aborted_r, aborted_s;
    logic [31:0] tgt_x_s, tgt_y_s;
    logic        at_tgt_s, tick_hit_s, dwell_hit_s, abort_go_s;

    // One axis moves at most STEP towards its target; a 33-bit difference cannot overflow.
    function automatic logic [31:0] step_toward(input logic [31:0] cur, input logic [31:0] tgt);
        logic signed [32:0] diff;
        logic [32:0]        mag;
        diff = $signed({tgt[31], tgt}) - $signed({cur[31], cur});
        if (diff[32]) begin
            mag = 33'(-diff);
        end else begin
            mag = 33'(diff);
        end
        if (mag <= {1'b0, STEP}) begin
            return tgt;
        end else if (diff[32]) begin
            return cur - STEP;
        end else begin
            return cur + STEP;
        end
    endfunction

    // Target of the current move leg and the per-cycle decision flags.
    always_comb begin
        tgt_x_s = HOME_X;
        tgt_y_s = HOME_Y;
        case (state_r)
            ST_TO_PICK: begin
                tgt_x_s = pick_x_r;
                tgt_y_s = pick_y_r;
            end
            ST_TO_PLACE: begin
                tgt_x_s = place_x_r;
                tgt_y_s = place_y_r;
            end
            default: begin
                tgt_x_s = HOME_X;
                tgt_y_s = HOME_Y;
            end
        endcase
        at_tgt_s    = (x_r == tgt_x_s) && (y_r == tgt_y_s);
        tick_hit_s  = (tick_r == TICK_DIV - 32'd1);
        dwell_hit_s = (dwell_r == DWELL - 32'd1);
        abort_go_s  = abort && (state_r != ST_IDLE) && (state_r != ST_TO_HOME);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s   = state_r;
        x_s       = x_r;
        y_s       = y_r;
        tick_s    = tick_r;
        dwell_s   = dwell_r;
        pick_x_s  = pick_x_r;
        pick_y_s  = pick_y_r;
        place_x_s = place_x_r;
        place_y_s = place_y_r;
        en_s      = en_r;
        catch_s   = catch_r;
        done_s    = 1'b0;
        aborted_s = aborted_r;

        if (abort_go_s) begin
            // Abort holds position this edge; the home leg starts a fresh tick.
            state_s   = ST_TO_HOME;
            catch_s   = 1'b0;
            aborted_s = 1'b1;
            tick_s    = 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    x_s       = HOME_X;
                    y_s       = HOME_Y;
                    en_s      = 1'b0;
                    catch_s   = 1'b0;
                    aborted_s = 1'b0;
                    tick_s    = 32'd0;
                    dwell_s   = 32'd0;
                    if (start && !abort) begin
                        pick_x_s  = pick_x;
                        pick_y_s  = pick_y;
                        place_x_s = place_x;
                        place_y_s = place_y;
                        en_s      = 1'b1;
                        state_s   = ST_TO_PICK;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_TO_PICK, ST_TO_PLACE, ST_TO_HOME: begin
                    if (at_tgt_s) begin
                        tick_s  = 32'd0;
                        dwell_s = 32'd0;
                        case (state_r)
                            ST_TO_PICK: begin
                                state_s = ST_GRIP;
                                catch_s = 1'b1;
                            end
                            ST_TO_PLACE: begin
                                state_s = ST_RELEASE;
                                catch_s = 1'b0;
                            end
                            default: begin
                                state_s   = ST_IDLE;
                                en_s      = 1'b0;
                                done_s    = !aborted_r;
                                aborted_s = 1'b0;
                            end
                        endcase
                    end else if (tick_hit_s) begin
                        tick_s = 32'd0;
                        x_s    = step_toward(x_r, tgt_x_s);
                        y_s    = step_toward(y_r, tgt_y_s);
                    end else begin
                        tick_s = tick_r + 32'd1;
                    end
                end
                ST_GRIP, ST_RELEASE: begin
                    if (dwell_hit_s) begin
                        dwell_s = 32'd0;
                        tick_s  = 32'd0;
                        if (state_r == ST_GRIP) begin
                            state_s = ST_TO_PLACE;
                        end else begin
                            state_s = ST_TO_HOME;
                        end
                    end else begin
                        dwell_s = dwell_r + 32'd1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    en_s    = 1'b0;
                    catch_s = 1'b0;
                end
            endcase
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            x_r       <= HOME_X;
            y_r       <= HOME_Y;
            tick_r    <= 32'd0;
            dwell_r   <= 32'd0;
            pick_x_r  <= 32'd0;
            pick_y_r  <= 32'd0;
            place_x_r <= 32'd0;
            place_y_r <= 32'd0;
            en_r      <= 1'b0;
            catch_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            x_r       <= x_s;
            y_r       <= y_s;
            tick_r    <= tick_s;
            dwell_r   <= dwell_s;
            pick_x_r  <= pick_x_s;
            pick_y_r  <= pick_y_s;
            place_x_r <= place_x_s;
            place_y_r <= place_y_s;
            en_r      <= en_s;
            catch_r   <= catch_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            aborted_r <= aborted_s;
        end
    end

    assign x     = x_r;
    assign y     = y_r;
    assign en    = en_r;
    assign catch = catch_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_arm_sequencer.sv
// Self-checking bench for arm_sequencer: a directed vector table, hand-written corner
// sequences and random stimulus, all checked against a trajectory-level reference model.
module tb_arm_sequencer;

    localparam logic [31:0] P_TICK  = 32'd4;
    localparam logic [31:0] P_STEP  = 32'h0001_0000;
    localparam logic [31:0] P_DWELL = 32'd10;
    localparam logic [31:0] P_HX    = 32'h0000_0000;
    localparam logic [31:0] P_HY    = 32'h0005_0000;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [31:0] pick_x, pick_y, place_x, place_y;
    logic [31:0] x_s, y_s;
    logic        en_s, catch_s, busy_s, done_s;

    int n_vec = 0;
    int n_bad = 0;

    arm_sequencer #(
        .TICK_DIV(P_TICK), .STEP(P_STEP), .DWELL(P_DWELL), .HOME_X(P_HX), .HOME_Y(P_HY)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pick_x(pick_x), .pick_y(pick_y), .place_x(place_x), .place_y(place_y),
        .x(x_s), .y(y_s), .en(en_s), .catch(catch_s), .busy(busy_s), .done(done_s)
    );

    always #5 clk = ~clk;

    // Reference model: a run is expanded up front into the per-cycle output trajectory.
    typedef struct {
        logic [31:0] x, y;
        logic        en, ct, busy, done, abortable;
    } samp_t;

    samp_t       q[$];
    samp_t       cur_e;
    logic [31:0] mx, my;

    function automatic samp_t idle_samp(input logic d);
        samp_t s;
        s.x = P_HX; s.y = P_HY; s.en = 1'b0; s.ct = 1'b0;
        s.busy = 1'b0; s.done = d; s.abortable = 1'b0;
        return s;
    endfunction

    function automatic logic [31:0] approach(input logic [31:0] c, input logic [31:0] t);
        longint d;
        d = longint'($signed(t)) - longint'($signed(c));
        if (d <= longint'(P_STEP) && d >= -longint'(P_STEP)) return t;
        else if (d > 0) return c + P_STEP;
        else return c - P_STEP;
    endfunction

    task automatic push(input logic ct, input logic ab);
        samp_t s;
        s.x = mx; s.y = my; s.en = 1'b1; s.ct = ct;
        s.busy = 1'b1; s.done = 1'b0; s.abortable = ab;
        q.push_back(s);
    endtask

    task automatic gen_move(input logic [31:0] tx, input logic [31:0] ty,
                            input logic ct, input logic ab);
        push(ct, ab);
        while (mx != tx || my != ty) begin
            for (int i = 1; i < int'(P_TICK); i++) push(ct, ab);
            mx = approach(mx, tx);
            my = approach(my, ty);
            push(ct, ab);
        end
    endtask

    task automatic gen_home(input logic d);
        gen_move(P_HX, P_HY, 1'b0, 1'b0);
        q.push_back(idle_samp(d));
    endtask

    task automatic gen_run(input logic [31:0] px, input logic [31:0] py,
                           input logic [31:0] qx, input logic [31:0] qy);
        mx = P_HX;
        my = P_HY;
        gen_move(px, py, 1'b0, 1'b1);
        for (int i = 0; i < int'(P_DWELL); i++) push(1'b1, 1'b1);
        gen_move(qx, qy, 1'b1, 1'b1);
        for (int i = 0; i < int'(P_DWELL); i++) push(1'b0, 1'b1);
        gen_home(1'b1);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, predict, advance, compare all outputs against the model.
    task automatic step(input logic r, input logic s, input logic a,
                        input logic [31:0] px, input logic [31:0] py,
                        input logic [31:0] qx, input logic [31:0] qy);
        samp_t nxt;
        rst = r; start = s; abort = a;
        pick_x = px; pick_y = py; place_x = qx; place_y = qy;
        if (r) begin
            q.delete();
            nxt = idle_samp(1'b0);
        end else if (!cur_e.busy) begin
            if (s && !a) begin
                q.delete();
                gen_run(px, py, qx, qy);
                nxt = q.pop_front();
            end else begin
                nxt = idle_samp(1'b0);
            end
        end else begin
            if (a && cur_e.abortable) begin
                q.delete();
                mx = cur_e.x;
                my = cur_e.y;
                gen_home(1'b0);
            end
            if (q.size() > 0) nxt = q.pop_front();
            else nxt = idle_samp(1'b0);
        end
        cur_e = nxt;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({x_s, y_s, en_s, catch_s, busy_s, done_s} !==
            {nxt.x, nxt.y, nxt.en, nxt.ct, nxt.busy, nxt.done}) begin
            n_bad++;
            $display("FAIL model t=%0t: x=%h y=%h en=%b catch=%b busy=%b done=%b, expected x=%h y=%h en=%b catch=%b busy=%b done=%b",
                     $time, x_s, y_s, en_s, catch_s, busy_s, done_s,
                     nxt.x, nxt.y, nxt.en, nxt.ct, nxt.busy, nxt.done);
        end
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, P_HX, P_HY, P_HX, P_HY);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((cur_e.busy || q.size() != 0) && n < 2000) begin
            idle_step();
            n++;
        end
        check({name, "_drain_bound"}, (n < 2000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] rnd_coord();
        return $urandom_range(32'h0008_0000, 32'd0) - 32'h0004_0000;
    endfunction

    typedef struct {
        logic        r, s, a;
        logic [31:0] ex, ey;
        logic        een, ect, ebusy, edone;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic r, input logic s, input logic a,
                                 input logic een, input logic ect,
                                 input logic ebusy, input logic edone);
        vec_t v;
        v.r = r; v.s = s; v.a = a; v.ex = P_HX; v.ey = P_HY;
        v.een = een; v.ect = ect; v.ebusy = ebusy; v.edone = edone;
        return v;
    endfunction

    initial begin
        int          dn;
        int          cnt;
        logic [31:0] xs[$];

        // Directed table: reset, then a run with pick = place = home (all pass-through legs).
        tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mkv(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 10; i++) tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        for (int i = 0; i < 10; i++) tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        pick_x = P_HX; pick_y = P_HY; place_x = P_HX; place_y = P_HY;
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; start = tbl[i].s; abort = tbl[i].a;
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if ({x_s, y_s, en_s, catch_s, busy_s, done_s} !==
                {tbl[i].ex, tbl[i].ey, tbl[i].een, tbl[i].ect, tbl[i].ebusy, tbl[i].edone}) begin
                n_bad++;
                $display("FAIL table[%0d]: x=%h y=%h en=%b catch=%b busy=%b done=%b, expected x=%h y=%h en=%b catch=%b busy=%b done=%b",
                         i, x_s, y_s, en_s, catch_s, busy_s, done_s, tbl[i].ex, tbl[i].ey,
                         tbl[i].een, tbl[i].ect, tbl[i].ebusy, tbl[i].edone);
            end
        end
        cur_e = idle_samp(1'b0);

        // Reference run: x ramps 0 -> 1.0 -> 2.0 at 4-cycle intervals, done pulses once.
        step(1'b0, 1'b1, 1'b0, 32'h0002_0000, 32'h0005_0000, 32'hFFFF_0000, 32'h0004_8000);
        xs.push_back(x_s);
        dn = 0;
        cnt = 0;
        while ((cur_e.busy || q.size() != 0) && cnt < 2000) begin
            idle_step();
            xs.push_back(x_s);
            if (done_s === 1'b1) dn++;
            cnt++;
        end
        check("ref_x_k3", xs[3], 32'h0000_0000);
        check("ref_x_k4", xs[4], 32'h0001_0000);
        check("ref_x_k8", xs[8], 32'h0002_0000);
        check("ref_done_count", 32'(dn), 32'd1);
        check("ref_final_y", y_s, P_HY);

        // start held high for the whole run while targets wander: one run to the latched targets.
        step(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h0004_0000, 32'hFFFF_8000, 32'h0006_0000);
        dn = 0;
        cnt = 0;
        while (cur_e.busy && cnt < 2000) begin
            step(1'b0, 1'b1, 1'b0, rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord());
            if (done_s === 1'b1) dn++;
            cnt++;
        end
        check("hold_start_done_count", 32'(dn), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord());
        step(1'b0, 1'b0, 1'b1, P_HX, P_HY, P_HX, P_HY);
        drain("hold_start");

        // Abort during GRIP: catch drops on the abort edge and no done pulse follows.
        step(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h0005_0000, 32'h0002_0000, 32'h0003_0000);
        cnt = 0;
        while (!cur_e.ct && cnt < 100) begin
            idle_step();
            cnt++;
        end
        for (int i = 0; i < 3; i++) idle_step();
        check("abort_pre_catch", 32'(catch_s), 32'd1);
        step(1'b0, 1'b0, 1'b1, P_HX, P_HY, P_HX, P_HY);
        check("abort_catch_low", 32'(catch_s), 32'd0);
        dn = 0;
        cnt = 0;
        while ((cur_e.busy || q.size() != 0) && cnt < 2000) begin
            idle_step();
            if (done_s === 1'b1) dn++;
            cnt++;
        end
        check("abort_done_count", 32'(dn), 32'd0);
        check("abort_busy_low", 32'(busy_s), 32'd0);

        // Reset in the middle of TO_PLACE, then a normal run.
        step(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h0005_0000, 32'hFFFD_0000, 32'h0002_0000);
        cnt = 0;
        while (!cur_e.ct && cnt < 100) begin
            idle_step();
            cnt++;
        end
        for (int i = 0; i < int'(P_DWELL) + 3; i++) idle_step();
        step(1'b1, 1'b0, 1'b0, P_HX, P_HY, P_HX, P_HY);
        check("rst_mid_x", x_s, P_HX);
        check("rst_mid_flags", {28'd0, en_s, catch_s, busy_s, done_s}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0006_8000, 32'h0000_8000, 32'h0004_0000);
        drain("after_rst");

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(1499, 0) == 0), ($urandom_range(3, 0) == 0),
                 ($urandom_range(79, 0) == 0),
                 rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord());
        end
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
